data_memory_bank: RTL and testbench

DATA_MEMORY_BANK -- requirements
Module: data_memory_bank

---
 rtl/data_mem_pkg.sv | 40 ++++
 rtl/data_mem_array.sv | 39 +++
 rtl/data_memory_bank.sv | 154 +++++++++++++++
 tb/tb_data_memory_bank.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared encodings for the data memory bank
//
// Purpose: request size encoding, response error-code encoding, FSM state
//          type and the store byte-lane mask helper.
// Ports:   none (package)

package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_SIZE     = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Byte lanes touched by an access of the given size at byte offset lo.
  function automatic logic [3:0] lane_mask(size_e sz, logic [1:0] lo);
    logic [3:0] m;
    case (sz)
      SZ_BYTE: m = 4'b0001 << lo;
      SZ_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - single-port synchronous RAM with byte-write enables
//
// Purpose: DEPTH x 32-bit storage; registered read; no reset on contents.
// Ports:   clk   - clock
//          en    - access enable (read or write this edge)
//          we    - write when en=1
//          be    - per-byte write enables, bit i covers wdata[8i+7:8i]
//          addr  - word index
//          wdata - write data, already lane-aligned
//          rdata - read data, updated only on enabled edges

module data_mem_array #(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      // Holding rdata between enabled edges keeps a pending load result stable.
      rdata <= r_mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_bank.sv
// rtl/data_memory_bank.sv - request/response data memory with error checks
//
// Purpose: accepts one load/store at a time, checks size/alignment/range,
//          waits WAIT_CYCLES, performs the access and holds the response
//          until consumed.
// Ports:   clk, rst_n                       - clock, sync active-low reset
//          req_valid/req_ready              - request handshake
//          req_we, req_size, req_unsigned   - access kind
//          req_addr, req_wdata              - byte address, right-aligned data
//          rsp_valid/rsp_ready              - response handshake
//          rsp_rdata, rsp_err_code          - load result, error code

import data_mem_pkg::*;

module data_memory_bank #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err_code
);

  localparam int IDX_W = $clog2(DEPTH);

  state_e            r_state, w_next;
  logic [3:0]        r_cnt;
  logic              r_we, r_unsigned;
  size_e             r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  err_e              r_err;

  logic              w_idle, w_accept, w_enter_resp, w_misalign, w_oor;
  logic              w_cur_we;
  size_e             w_cur_size;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [31:0]       w_cur_wdata, w_lane_wdata, w_ram_q, w_ld_data;
  err_e              w_cur_err;
  logic [7:0]        w_ld_byte;
  logic [15:0]       w_ld_half;

  assign w_idle    = (r_state == ST_IDLE);
  assign req_ready = rst_n && w_idle;
  assign w_accept  = req_valid && req_ready;

  // With no wait cycles the access happens on the accept edge, so in IDLE the
  // live request drives the array; otherwise the captured copy does.
  assign w_cur_we    = w_idle ? req_we            : r_we;
  assign w_cur_size  = w_idle ? size_e'(req_size) : r_size;
  assign w_cur_addr  = w_idle ? req_addr          : r_addr;
  assign w_cur_wdata = w_idle ? req_wdata         : r_wdata;

  assign w_misalign = ((w_cur_size == SZ_HALF) && w_cur_addr[0]) ||
                      ((w_cur_size == SZ_WORD) && (w_cur_addr[1:0] != 2'b00));
  // Any set bit above the word index is out of range; no wrap-around.
  assign w_oor      = |w_cur_addr[ADDR_W-1:IDX_W+2];

  always_comb begin
    w_cur_err = ERR_OK;
    if (w_cur_size == SZ_ILLEGAL) w_cur_err = ERR_SIZE;
    else if (w_misalign)          w_cur_err = ERR_MISALIGN;
    else if (w_oor)               w_cur_err = ERR_RANGE;
  end

  always_comb begin
    w_lane_wdata = w_cur_wdata;
    case (w_cur_size)
      SZ_BYTE: w_lane_wdata = {4{w_cur_wdata[7:0]}};
      SZ_HALF: w_lane_wdata = {2{w_cur_wdata[15:0]}};
      default: w_lane_wdata = w_cur_wdata;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (r_cnt == 4'd1) w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Gating with rst_n keeps a store that meets reset from committing.
  assign w_enter_resp = rst_n && (r_state != ST_RESP) && (w_next == ST_RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_size     <= SZ_BYTE;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err      <= ERR_OK;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we       <= req_we;
        r_size     <= size_e'(req_size);
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_err      <= w_cur_err;
        r_cnt      <= 4'(WAIT_CYCLES);
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  data_mem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .en    (w_enter_resp && (w_cur_err == ERR_OK)),
    .we    (w_cur_we),
    .be    (lane_mask(w_cur_size, w_cur_addr[1:0])),
    .addr  (w_cur_addr[IDX_W+1:2]),
    .wdata (w_lane_wdata),
    .rdata (w_ram_q)
  );

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_ld_byte = w_ram_q[7:0];
      2'd1:    w_ld_byte = w_ram_q[15:8];
      2'd2:    w_ld_byte = w_ram_q[23:16];
      default: w_ld_byte = w_ram_q[31:24];
    endcase
    w_ld_half = r_addr[1] ? w_ram_q[31:16] : w_ram_q[15:0];
    case (r_size)
      SZ_BYTE: w_ld_data = {{24{~r_unsigned & w_ld_byte[7]}}, w_ld_byte};
      SZ_HALF: w_ld_data = {{16{~r_unsigned & w_ld_half[15]}}, w_ld_half};
      default: w_ld_data = w_ram_q;
    endcase
  end

  assign rsp_valid    = (r_state == ST_RESP);
  assign rsp_rdata    = (rsp_valid && !r_we && (r_err == ERR_OK)) ? w_ld_data : 32'd0;
  assign rsp_err_code = rsp_valid ? r_err : ERR_OK;

endmodule

// File: tb/tb_data_memory_bank.sv
// tb/tb_data_memory_bank.sv - directed self-checking bench for data_memory_bank

module tb_data_memory_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // a_*: WAIT_CYCLES=0 instance, b_*: WAIT_CYCLES=3 instance
  logic        a_rst_n, a_req_valid, a_req_ready, a_req_we, a_req_unsigned;
  logic [1:0]  a_req_size, a_rsp_err_code;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic        a_rsp_valid, a_rsp_ready;
  logic        b_rst_n, b_req_valid, b_req_ready, b_req_we, b_req_unsigned;
  logic [1:0]  b_req_size, b_rsp_err_code;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic        b_rsp_valid, b_rsp_ready;

  data_memory_bank #(.ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(a_rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_we(a_req_we), .req_size(a_req_size), .req_unsigned(a_req_unsigned),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .rsp_valid(a_rsp_valid),
    .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err_code(a_rsp_err_code)
  );

  data_memory_bank #(.ADDR_W(32), .DEPTH(256), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_we(b_req_we), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err_code(b_rsp_err_code)
  );

  task automatic drive(input int sel, input logic v, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input logic rr);
    if (sel == 0) begin
      a_req_valid = v; a_req_we = we; a_req_size = sz; a_req_unsigned = uns;
      a_req_addr = addr; a_req_wdata = wd; a_rsp_ready = rr;
    end else begin
      b_req_valid = v; b_req_we = we; b_req_size = sz; b_req_unsigned = uns;
      b_req_addr = addr; b_req_wdata = wd; b_rsp_ready = rr;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? a_req_ready : b_req_ready;
  endfunction
  function automatic logic vld(input int sel);
    return (sel == 0) ? a_rsp_valid : b_rsp_valid;
  endfunction

  // One full transaction with rsp_ready=1; lat counts edges from accept to rsp_valid.
  task automatic xact(input int sel, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic [1:0] ec, output int lat);
    int guard;
    @(negedge clk);
    drive(sel, 1'b1, we, sz, uns, addr, wd, 1'b1);
    guard = 0;
    while (!rdy(sel) && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1);
    lat = 1;
    while (!vld(sel) && lat < 40) begin @(posedge clk); #1; lat++; end
    rd = (sel == 0) ? a_rsp_rdata : b_rsp_rdata;
    ec = (sel == 0) ? a_rsp_err_code : b_rsp_err_code;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0);
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready_low got=%b exp=0", a_req_ready); end
    checks++; if (a_rsp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", a_rsp_rdata); end
    @(negedge clk); a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", a_req_ready); end
    checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL idle_rsp_valid got=%b exp=0", a_rsp_valid); end
    checks++; if (a_rsp_err_code !== 2'b00) begin failures++; $display("FAIL idle_err got=%b exp=00", a_rsp_err_code); end
    checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL idle_ready_w3 got=%b exp=1", b_req_ready); end
  endtask

  task automatic test_word_store_load;
    logic [31:0] rd; logic [1:0] ec; int lat;
    xact(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, ec, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL store_latency got=%0d exp=1", lat); end
    checks++; if (rd !== 32'd0 || ec !== 2'b00) begin failures++; $display("FAIL store_rsp got=%h/%b exp=0/00", rd, ec); end
    xact(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, rd, ec, lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL load_latency got=%0d exp=1", lat); end
    checks++; if (rd !== 32'hDEADBEEF || ec !== 2'b00) begin failures++; $display("FAIL word_load got=%h/%b exp=deadbeef/00", rd, ec); end
  endtask

  task automatic test_byte_half;
    logic [31:0] rd; logic [1:0] ec; int lat;
    xact(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h00000000, rd, ec, lat);
    xact(0, 1'b1, 2'b00, 1'b0, 32'h23, 32'h12345680, rd, ec, lat);
    xact(0, 1'b0, 2'b00, 1'b0, 32'h23, 32'd0, rd, ec, lat);
    checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL byte_signed got=%h exp=ffffff80", rd); end
    xact(0, 1'b0, 2'b00, 1'b1, 32'h23, 32'd0, rd, ec, lat);
    checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL byte_unsigned got=%h exp=00000080", rd); end
    xact(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, rd, ec, lat);
    checks++; if (rd !== 32'h80000000) begin failures++; $display("FAIL byte_word got=%h exp=80000000", rd); end
    xact(0, 1'b1, 2'b01, 1'b0, 32'h20, 32'hFFFF8001, rd, ec, lat);
    xact(0, 1'b0, 2'b01, 1'b0, 32'h20, 32'd0, rd, ec, lat);
    checks++; if (rd !== 32'hFFFF8001) begin failures++; $display("FAIL half_signed_lo got=%h exp=ffff8001", rd); end
    xact(0, 1'b0, 2'b01, 1'b1, 32'h22, 32'd0, rd, ec, lat);
    checks++; if (rd !== 32'h00008000) begin failures++; $display("FAIL half_unsigned_hi got=%h exp=00008000", rd); end
    xact(0, 1'b0, 2'b01, 1'b0, 32'h22, 32'd0, rd, ec, lat);
    checks++; if (rd !== 32'hFFFF8000) begin failures++; $display("FAIL half_signed_hi got=%h exp=ffff8000", rd); end
    xact(0, 1'b0, 2'b10, 1'b1, 32'h20, 32'd0, rd, ec, lat);
    checks++; if (rd !== 32'h80008001) begin failures++; $display("FAIL half_word got=%h exp=80008001", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic [1:0] ec; int lat;
    xact(0, 1'b0, 2'b01, 1'b0, 32'h21, 32'd0, rd, ec, lat);
    checks++; if (ec !== 2'b01 || rd !== 32'd0) begin failures++; $display("FAIL half_misalign got=%b/%h exp=01/0", ec, rd); end
    xact(0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h55AA55AA, rd, ec, lat);
    xact(0, 1'b1, 2'b10, 1'b0, 32'h400, 32'h99999999, rd, ec, lat);
    checks++; if (ec !== 2'b10 || rd !== 32'd0) begin failures++; $display("FAIL store_range got=%b/%h exp=10/0", ec, rd); end
    xact(0, 1'b0, 2'b10, 1'b0, 32'h0, 32'd0, rd, ec, lat);
    checks++; if (rd !== 32'h55AA55AA) begin failures++; $display("FAIL range_unchanged got=%h exp=55aa55aa", rd); end
    xact(0, 1'b0, 2'b11, 1'b0, 32'h23, 32'd0, rd, ec, lat);
    checks++; if (ec !== 2'b11 || rd !== 32'd0) begin failures++; $display("FAIL illegal_size got=%b/%h exp=11/0", ec, rd); end
    xact(0, 1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFFFFFF, rd, ec, lat);
    checks++; if (ec !== 2'b01) begin failures++; $display("FAIL word_misalign got=%b exp=01", ec); end
    xact(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, rd, ec, lat);
    checks++; if (rd !== 32'h80008001) begin failures++; $display("FAIL misalign_unchanged got=%h exp=80008001", rd); end
    xact(0, 1'b0, 2'b10, 1'b0, 32'h401, 32'd0, rd, ec, lat);
    checks++; if (ec !== 2'b01) begin failures++; $display("FAIL misalign_over_range got=%b exp=01", ec); end
    xact(0, 1'b0, 2'b10, 1'b0, 32'h80000010, 32'd0, rd, ec, lat);
    checks++; if (ec !== 2'b10 || rd !== 32'd0) begin failures++; $display("FAIL no_wrap got=%b/%h exp=10/0", ec, rd); end
  endtask

  task automatic test_latency_backpressure;
    logic [31:0] rd, held; logic [1:0] ec; int lat;
    xact(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0BADF00D, rd, ec, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL w3_store_latency got=%0d exp=4", lat); end
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b0);
    lat = 1;
    while (!b_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 4) begin failures++; $display("FAIL w3_load_latency got=%0d exp=4", lat); end
    held = b_rsp_rdata;
    checks++; if (held !== 32'h0BADF00D) begin failures++; $display("FAIL w3_load_data got=%h exp=0badf00d", held); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 32'h0BADF00D || b_req_ready !== 1'b0 || b_rsp_err_code !== 2'b00) begin
        failures++;
        $display("FAIL backpressure_hold cyc=%0d got=v%b d=%h r%b e%b exp=v1 d=0badf00d r0 e00",
                 i, b_rsp_valid, b_rsp_rdata, b_req_ready, b_rsp_err_code);
      end
    end
    // A request already waiting must not be taken on the response handshake edge.
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 1'b1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1);
    checks++; if (b_rsp_valid !== 1'b0 || b_req_ready !== 1'b1) begin failures++; $display("FAIL handshake_release got=v%b r%b exp=v0 r1", b_rsp_valid, b_req_ready); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (b_req_ready !== 1'b1) begin failures++; $display("FAIL no_same_edge_accept got=%b exp=1", b_req_ready); end
  endtask

  task automatic test_reset_mid_access;
    logic [31:0] rd; logic [1:0] ec; int lat;
    xact(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, rd, ec, lat);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, 1'b1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 1'b1);
    @(posedge clk);
    @(negedge clk); b_rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (b_req_ready !== 1'b0 || b_rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_outputs got=r%b v%b exp=r0 v0", b_req_ready, b_rsp_valid); end
    @(negedge clk); b_rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (b_rsp_valid !== 1'b0 || b_req_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_discard got=v%b r%b exp=v0 r1", b_rsp_valid, b_req_ready); end
    xact(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, rd, ec, lat);
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL mid_reset_no_commit got=%h exp=cafef00d", rd); end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_half();
    test_errors();
    test_latency_backpressure();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
